// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads the ID word and the timestamp word from the
// system-ID slave, compares them with the build values and gates boot through done.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h694B_C6B6,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        done,
    output logic        match,
    output logic        timeout,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, DONE} state_t;

    localparam logic [1:0]  LAT_LOAD  = 2'(READ_LATENCY);
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state;
    logic [1:0]  lat_cnt;
    logic [15:0] tmo_cnt;
    logic        auto_pending;
    logic        is_rd;
    logic        ts_phase;
    logic        capture;
    logic        tmo_hit;

    // Capture happens on accept for zero-latency slaves, otherwise when the latency count expires.
    always_comb begin
        is_rd    = (state == RD_ID) || (state == RD_TS);
        ts_phase = (state == RD_TS) || (state == LAT_TS);
        capture  = 1'b0;
        if (is_rd)
            capture = (READ_LATENCY == 0) && !avm_waitrequest;
        else if ((state == LAT_ID) || (state == LAT_TS))
            capture = (lat_cnt == 2'd1);
        tmo_hit = (tmo_cnt + 16'd1) == TMO_LIMIT;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            lat_cnt      <= 2'd0;
            tmo_cnt      <= 16'd0;
            auto_pending <= AUTO_START;
            avm_address  <= 1'b0;
            avm_read     <= 1'b0;
            id_value     <= 32'd0;
            ts_value     <= 32'd0;
            done         <= 1'b0;
            match        <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            auto_pending <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if ((state == IDLE && auto_pending) || start) begin
                        state       <= RD_ID;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        tmo_cnt     <= 16'd0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        match       <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                RD_ID, RD_TS, LAT_ID, LAT_TS: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (capture) begin
                        if (ts_phase) begin
                            ts_value <= avm_readdata;
                            state    <= CHECK;
                            avm_read <= 1'b0;
                        end else begin
                            id_value    <= avm_readdata;
                            state       <= RD_TS;
                            avm_read    <= 1'b1;
                            avm_address <= 1'b1;
                            tmo_cnt     <= 16'd0;
                        end
                    end else if (tmo_hit) begin
                        state    <= DONE;
                        avm_read <= 1'b0;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                        match    <= 1'b0;
                        busy     <= 1'b0;
                    end else if (is_rd && !avm_waitrequest) begin
                        state    <= ts_phase ? LAT_TS : LAT_ID;
                        avm_read <= 1'b0;
                        lat_cnt  <= LAT_LOAD;
                    end else if (!is_rd) begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                CHECK: begin
                    match <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker: a zero-latency instance and a
// two-cycle-latency instance with a stalling slave, each with its own slave model.
`timescale 1ns/1ps
module tb_sysid_boot_checker;
    localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;
    localparam logic [31:0] GOOD_TS = 32'h694B_C6B6;

    logic        clock = 1'b0;
    logic        rst0_n, rst2_n, start0, start2, wr0, wr2;
    logic        addr0, rd0, done0, match0, tmo0, busy0;
    logic        addr2, rd2, done2, match2, tmo2, busy2;
    logic [31:0] rdata0, rdata2, id0, ts0, id2, ts2;
    logic [31:0] id_word = 32'h0;
    logic [31:0] ts_word = GOOD_TS;
    logic [1:0]  pend2   = 2'd0;
    logic        paddr2  = 1'b0;
    int          stall2  = 0;
    int          tests   = 0;
    int          fails   = 0;
    int          reads, cycles, first_rd;

    always #5 clock = ~clock;

    sysid_boot_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(16)) dut0 (
        .clock(clock), .reset_n(rst0_n), .start(start0),
        .avm_address(addr0), .avm_read(rd0), .avm_waitrequest(wr0), .avm_readdata(rdata0),
        .id_value(id0), .ts_value(ts0), .done(done0), .match(match0), .timeout(tmo0), .busy(busy0)
    );

    sysid_boot_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(16)) dut2 (
        .clock(clock), .reset_n(rst2_n), .start(start2),
        .avm_address(addr2), .avm_read(rd2), .avm_waitrequest(wr2), .avm_readdata(rdata2),
        .id_value(id2), .ts_value(ts2), .done(done2), .match(match2), .timeout(tmo2), .busy(busy2)
    );

    // Zero-wait slave for dut0; junk outside a read exposes mistimed captures.
    assign rdata0 = rd0 ? (addr0 ? ts_word : id_word) : JUNK;

    // Latency-2 slave for dut2, stalling each read for 3 cycles.
    assign wr2    = rd2 && (stall2 < 3);
    assign rdata2 = (pend2 == 2'd1) ? (paddr2 ? ts_word : id_word) : JUNK;
    always @(posedge clock) begin
        stall2 <= (rd2 && wr2) ? stall2 + 1 : 0;
        if (rd2 && !wr2) begin
            pend2  <= 2'd2;
            paddr2 <= addr2;
        end else if (pend2 != 2'd0) begin
            pend2 <= pend2 - 2'd1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit sel, input int budget, output int n_reads,
                             output int n_cycles, output int n_first);
        n_reads  = 0;
        n_cycles = 0;
        n_first  = -1;
        while (n_cycles < budget) begin
            @(negedge clock);
            n_cycles++;
            if ((sel ? rd2 : rd0) && n_first < 0) n_first = n_cycles;
            if (sel ? (rd2 && !wr2) : (rd0 && !wr0)) n_reads++;
            if (sel ? done2 : done0) return;
        end
        check_eq("done_within_budget", 32'(sel ? done2 : done0), 32'd1);
    endtask

    task automatic reset0();
        @(posedge clock);
        #1 rst0_n = 1'b0;
        @(posedge clock);
        #1 rst0_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst0_n = 1'b0;
        rst2_n = 1'b0;
        start0 = 1'b0;
        start2 = 1'b0;
        wr0    = 1'b0;
        #22;
        check_eq("rst0_ctrl", 32'({rd0, addr0, done0, match0, tmo0, busy0}), 32'd0);
        check_eq("rst0_words", id0 | ts0, 32'd0);
        check_eq("rst2_ctrl", 32'({rd2, addr2, done2, match2, tmo2, busy2}), 32'd0);

        // Zero-wait auto sequence
        @(posedge clock);
        #1 rst0_n = 1'b1;
        reads = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (rd0 && !wr0) reads++;
            if (k == 1) check_eq("t1_rd_id", 32'({rd0, addr0, busy0}), 32'b101);
            if (k == 2) check_eq("t1_rd_ts", 32'({rd0, addr0, busy0}), 32'b111);
            if (k == 2) check_eq("t1_id", id0, 32'h0);
            if (k == 3) check_eq("t1_check", 32'({rd0, done0, busy0}), 32'b001);
            if (k == 3) check_eq("t1_ts", ts0, GOOD_TS);
            if (k == 4) check_eq("t1_done", 32'({done0, match0, busy0, tmo0}), 32'b1100);
        end
        check_eq("t1_reads", 32'(reads), 32'd2);

        // Timestamp off by one
        ts_word = GOOD_TS ^ 32'h1;
        reset0();
        wait_done(1'b0, 20, reads, cycles, first_rd);
        check_eq("t2_flags", 32'({done0, match0, tmo0}), 32'b100);
        check_eq("t2_ts", ts0, 32'h694B_C6B7);
        ts_word = GOOD_TS;

        // Stuck waitrequest
        wr0 = 1'b1;
        reset0();
        wait_done(1'b0, 40, reads, cycles, first_rd);
        check_eq("t4_tmo_cycles", 32'(cycles - first_rd), 32'd16);
        check_eq("t4_flags", 32'({done0, tmo0, match0, rd0, busy0}), 32'b11000);
        check_eq("t4_reads", 32'(reads), 32'd0);
        repeat (3) @(negedge clock);
        check_eq("t4_rd_after", 32'(rd0), 32'd0);

        // Rerun from DONE; a second start while busy is ignored
        wr0 = 1'b0;
        @(posedge clock);
        #1 start0 = 1'b1;
        @(posedge clock);
        #1 start0 = 1'b0;
        @(negedge clock);
        check_eq("t5_entry", 32'({done0, tmo0, match0, busy0}), 32'b0001);
        reads = (rd0 && !wr0) ? 1 : 0;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clock);
            #1 start0 = (j == 1 || j == 2);
            @(negedge clock);
            if (rd0 && !wr0) reads++;
        end
        check_eq("t5_reads", 32'(reads), 32'd2);
        check_eq("t5_final", 32'({done0, match0, tmo0, busy0}), 32'b1100);

        // Stalling slave with two-cycle read latency
        @(posedge clock);
        #1 rst2_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k <= 4) check_eq("t3_stall_hold", 32'({rd2, addr2}), 32'b10);
            if (k == 6) check_eq("t3_lat_rd", 32'(rd2), 32'd0);
            if (k == 7) check_eq("t3_rd_ts", 32'({rd2, addr2}), 32'b11);
            if (k == 7) check_eq("t3_id", id2, 32'h0);
            if (k == 12) check_eq("t3_ts_early", ts2, 32'h0);
            if (k == 13) check_eq("t3_ts", ts2, GOOD_TS);
            if (k == 14) check_eq("t3_done", 32'({done2, match2, busy2, tmo2}), 32'b1100);
        end

        // Reset during LAT_TS, then a fresh auto sequence
        @(posedge clock);
        #1 rst2_n = 1'b0;
        @(posedge clock);
        #1 rst2_n = 1'b1;
        repeat (11) @(posedge clock);
        #2;
        check_eq("t6_in_lat_ts", 32'({busy2, rd2, addr2}), 32'b101);
        rst2_n = 1'b0;
        #1;
        check_eq("t6_async_ctrl", 32'({rd2, addr2, done2, match2, tmo2, busy2}), 32'd0);
        check_eq("t6_async_words", id2 | ts2, 32'd0);
        @(posedge clock);
        #1 rst2_n = 1'b1;
        wait_done(1'b1, 40, reads, cycles, first_rd);
        check_eq("t6_final", 32'({done2, match2, tmo2}), 32'b110);
        check_eq("t6_ts", ts2, GOOD_TS);
        check_eq("t6_reads", 32'(reads), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
